rb_stream_arbiter: RTL and testbench
====================================

Name: rb_stream_arbiter

Overview:
Shares one combinational reverse_bits datapath (W bits) among N requesters. It uses round-robin arbitration with a valid/ready handshake on both sides. The output is a single registered result slot carrying the reversed word, the requester ID and a completed-transaction counter. It sits between the multiple bit-reverse clients and a single downstream consumer.

Parameters:
W, 16, data word width; also the width of the shared reverse_bits instance
N, 4, number of requesters (N >= 2)
ID_W, $clog2(N), width of the requester ID (derived; not overridden)
CNT_W, 16, width of the transaction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  N  per-requester valid; bit i belongs to requester i
req_data  input  N*W  requester i word at bits [i*W +: W]
req_ready  output  N  one-hot grant/accept; at most one bit high
out_valid  output  1  result slot holds a valid result
out_data  output  W  bit-reversed word: out_data[k] = granted din[W-1-k]
out_id  output  ID_W  index of the requester that produced out_data
out_ready  input  1  downstream accepts the result
out_count  output  CNT_W  number of results consumed (out_valid && out_ready)

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, out_data=0, out_id=0, out_count=0, priority pointer ptr=0. rst wins over every simultaneous event. An in-flight result is discarded.
- Slot free: can_accept = !out_valid || out_ready (combinational).
- Grant (combinational):
  - When can_accept and !rst, g = first i with req_valid[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
  - req_ready = one-hot(g) if any req_valid, else 0.
  - req_ready is all zero when !can_accept or rst=1.
- Accept (edge where req_valid[g] && req_ready[g]):
  - out_data <= reverse(req_data[g]); out_id <= g; out_valid <= 1.
  - ptr <= (g+1) mod N.
- Consume (edge where out_valid && out_ready):
  - out_count <= out_count+1, wrapping at 2^CNT_W-1 -> 0.
  - If no accept happens on the same edge, out_valid <= 0.
- Consume and accept on the same edge: the slot reloads with the new result and out_valid stays 1. This gives full throughput of one word per cycle.
- Latency: a word accepted at edge t is visible on out_* after edge t, i.e. in cycle t+1.
- Holding: while out_valid && !out_ready, out_data and out_id are held stable and ptr does not change.
- Datapath: the reverse_bits instance is driven by a W-bit mux of req_data selected by g. No pipeline stages are inside the reverse datapath.
- Requester obligations:
  - req_data[i] must be stable while req_valid[i]=1 and not granted.
  - A requester may drop req_valid without a grant.
  - The arbiter does not require valid to be held.
- State machine (encoded by out_valid):
  - EMPTY to FULL on accept.
  - FULL to EMPTY on consume without accept.
  - FULL to FULL on consume with accept, or on stall.
  - EMPTY to EMPTY when no req_valid.
- No starvation: with all requesters continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
- X handling: req_data of non-granted requesters is don't-care.

Test Plan:
1. Reset: hold rst=1 with req_valid=4'b1111 and out_ready=1 -> req_ready=0, out_valid=0, out_data=0, out_count=0. Release rst; the first grant is to requester 0.
2. Single request: requester 2 sends 16'h8078 with out_ready=1, accepted at edge t -> in cycle t+1, out_valid=1, out_data=16'h1E01, out_id=2. The next edge consumes it, then out_valid=0 and out_count=1.
3. Full contention: requesters 0..3 hold req_valid with data 16'h8078, 16'hF000, 16'h8007, 16'h0001 and out_ready=1 -> one result per cycle with out_id 0,1,2,3,0. out_data is 1E01, 000F, E001, 8000, 1E01. out_count increments every cycle.
4. Backpressure: with out_valid=1 holding 16'h000F (id 1), drive out_ready=0 for 3 cycles while req_valid=4'b1101 -> req_ready=0, and out_data and out_id are unchanged. When out_ready goes to 1, that edge consumes and accepts requester 2 (ptr=2) in the same cycle, with out_data=16'hE001.
5. Round-robin skip: last grant was 1 (ptr=2) and req_valid=4'b1010 -> grant 3, then grant 1, then grant 3.
6. Reset mid-operation: out_valid=1, out_ready=0, out_count=5; assert rst for one cycle -> next cycle out_valid=0, out_count=0, ptr=0, and the pending result is lost.

Source files
------------

// File: rtl/rb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rb_stream_arbiter
//
// Purpose:
//   N requesters share one combinational bit-reverse datapath. A round-robin
//   arbiter picks one requester whenever the output slot can accept a word.
//   The reversed word, the winning requester ID and a count of consumed
//   results are held in a single registered output slot. The slot sustains
//   one word per cycle when downstream is always ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  [N]      per-requester valid
//   req_data   [N*W]    requester i word at bits [i*W +: W]
//   req_ready  [N]      one-hot accept strobe (all zero when nothing is accepted)
//   out_valid           result slot holds a valid result
//   out_data   [W]      bit-reversed word of the granted requester
//   out_id     [ID_W]   index of the requester that produced out_data
//   out_ready           downstream accepts the result this cycle
//   out_count  [CNT_W]  number of results consumed, wraps to zero
// -----------------------------------------------------------------------------

// Pure wiring bit reversal: dout[k] = din[W-1-k].
module reverse_bits #(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  for (genvar k = 0; k < W; k++) begin : g_rev
    assign dout[k] = din[W-1-k];
  end
endmodule

module rb_stream_arbiter #(
  parameter  int W     = 16,
  parameter  int N     = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*W-1:0]     req_data,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count
);

  // The slot state is exactly out_valid: EMPTY or FULL.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t     state;
  logic [ID_W-1:0] ptr;        // requester with highest priority next time
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;
  logic            grant_any;
  logic            can_accept;
  logic            accept;
  logic            consume;
  logic [W-1:0]    mux_data;
  logic [W-1:0]    rev_data;
  int              idx;

  assign out_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) || out_ready;
  assign consume    = (state == FULL) && out_ready;

  // Round-robin search starting at ptr and wrapping modulo N.
  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves a value to be remembered (no latch).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // rst and a stalled slot both suppress the grant; the handshake is then
  // simply accept, since req_ready is only raised for a valid requester.
  assign accept    = can_accept && !rst && grant_any;
  assign req_ready = accept ? (N'(1) << grant_idx) : '0;
  assign next_ptr  = (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + ID_W'(1);

  // Shared datapath: one W-bit mux feeding the single reverse instance.
  assign mux_data = req_data[grant_idx*W +: W];

  reverse_bits #(.W(W)) u_reverse_bits (
    .din  (mux_data),
    .dout (rev_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_id    <= '0;
      out_count <= '0;
      ptr       <= '0;
    end else begin
      if (consume) begin
        out_count <= out_count + CNT_W'(1);
      end
      // An accept on the consume edge reloads the slot, keeping it FULL.
      if (accept) begin
        state    <= FULL;
        out_data <= rev_data;
        out_id   <= grant_idx;
        ptr      <= next_ptr;
      end else if (consume) begin
        state    <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rb_stream_arbiter
//
// Self-checking bench for rb_stream_arbiter (W=16, N=4, CNT_W=16).
// A table of per-cycle vectors with hand-derived expectations covers reset,
// single requests, full contention, backpressure, round-robin skipping and
// reset mid-operation. A randomized phase then checks against a reference
// model whose expected results sit in a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_rb_stream_arbiter;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [ID_W-1:0]  out_id;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

  rb_stream_arbiter #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = d[W-1-k];
    return r;
  endfunction

  // Reference round-robin: first valid requester at or after ptr, wrapping.
  function automatic logic [ID_W-1:0] model_grant(input logic [N-1:0] rv,
                                                  input logic [ID_W-1:0] p,
                                                  output logic found);
    int i;
    found = 1'b0;
    i = int'(p);
    repeat (N) begin
      if (rv[i]) begin
        found = 1'b1;
        return ID_W'(i);
      end
      i = (i == N - 1) ? 0 : i + 1;
    end
    return '0;
  endfunction

  typedef struct {
    logic             rst;
    logic [N-1:0]     rv;
    logic             ordy;
    logic [N*W-1:0]   data;
    logic [N-1:0]     rr;
    logic             v;
    logic [W-1:0]     d;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] c;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] rv, input logic ordy,
                              input logic [N*W-1:0] data, input logic [N-1:0] rr,
                              input logic v, input logic [W-1:0] d,
                              input logic [ID_W-1:0] id, input logic [CNT_W-1:0] c);
    vec_t t;
    t.rst = r; t.rv = rv; t.ordy = ordy; t.data = data;
    t.rr = rr; t.v = v; t.d = d; t.id = id; t.c = c;
    return t;
  endfunction

  typedef struct {
    logic [W-1:0]    data;
    logic [ID_W-1:0] id;
  } res_t;

  res_t sb_q[$];

  localparam logic [N*W-1:0] DALL  = {16'h0001, 16'h8007, 16'hF000, 16'h8078};
  localparam logic [N*W-1:0] D2ONE = {16'h0000, 16'h8078, 16'h0000, 16'h0000};

  vec_t vecs[25];

  initial begin
    logic [ID_W-1:0]  m_ptr;
    logic [CNT_W-1:0] m_cnt;
    logic [N-1:0]     last_grant;
    logic [N-1:0]     exp_rr;
    logic [ID_W-1:0]  g;
    logic             found;
    logic             exp_valid;
    logic             can;
    res_t             r;

    // Columns: rst, req_valid, out_ready, data | req_ready, out_valid,
    // out_data, out_id, out_count (outputs seen before this row's edge).
    vecs[0]  = mk(1, 4'b1111, 1, DALL,  4'b0000, 0, 16'h0000, 0, 0); // in reset
    vecs[1]  = mk(0, 4'b0001, 1, DALL,  4'b0001, 0, 16'h0000, 0, 0); // first grant 0
    vecs[2]  = mk(0, 4'b0000, 1, DALL,  4'b0000, 1, 16'h1E01, 0, 0);
    vecs[3]  = mk(0, 4'b0100, 1, D2ONE, 4'b0100, 0, 16'h1E01, 0, 1); // single req 2
    vecs[4]  = mk(0, 4'b0000, 1, D2ONE, 4'b0000, 1, 16'h1E01, 2, 1);
    vecs[5]  = mk(1, 4'b1111, 1, DALL,  4'b0000, 0, 16'h1E01, 2, 2); // re-reset
    vecs[6]  = mk(0, 4'b1111, 1, DALL,  4'b0001, 0, 16'h0000, 0, 0); // contention
    vecs[7]  = mk(0, 4'b1111, 1, DALL,  4'b0010, 1, 16'h1E01, 0, 0);
    vecs[8]  = mk(0, 4'b1111, 1, DALL,  4'b0100, 1, 16'h000F, 1, 1);
    vecs[9]  = mk(0, 4'b1111, 1, DALL,  4'b1000, 1, 16'hE001, 2, 2);
    vecs[10] = mk(0, 4'b1111, 1, DALL,  4'b0001, 1, 16'h8000, 3, 3);
    vecs[11] = mk(0, 4'b1111, 1, DALL,  4'b0010, 1, 16'h1E01, 0, 4);
    vecs[12] = mk(0, 4'b1101, 0, DALL,  4'b0000, 1, 16'h000F, 1, 5); // backpressure
    vecs[13] = mk(0, 4'b1101, 0, DALL,  4'b0000, 1, 16'h000F, 1, 5);
    vecs[14] = mk(0, 4'b1101, 0, DALL,  4'b0000, 1, 16'h000F, 1, 5);
    vecs[15] = mk(0, 4'b1101, 1, DALL,  4'b0100, 1, 16'h000F, 1, 5); // consume+accept
    vecs[16] = mk(0, 4'b0010, 1, DALL,  4'b0010, 1, 16'hE001, 2, 6); // ptr 3 wraps to 1
    vecs[17] = mk(0, 4'b1010, 1, DALL,  4'b1000, 1, 16'h000F, 1, 7); // rr skip
    vecs[18] = mk(0, 4'b1010, 1, DALL,  4'b0010, 1, 16'h8000, 3, 8);
    vecs[19] = mk(0, 4'b1010, 1, DALL,  4'b1000, 1, 16'h000F, 1, 9);
    vecs[20] = mk(0, 4'b0000, 0, DALL,  4'b0000, 1, 16'h8000, 3, 10); // stall
    vecs[21] = mk(1, 4'b1111, 0, DALL,  4'b0000, 1, 16'h8000, 3, 10); // reset mid-op
    vecs[22] = mk(0, 4'b0010, 0, DALL,  4'b0010, 0, 16'h0000, 0, 0);  // ptr back at 0
    vecs[23] = mk(0, 4'b0000, 1, DALL,  4'b0000, 1, 16'h000F, 1, 0);
    vecs[24] = mk(0, 4'b0000, 0, DALL,  4'b0000, 0, 16'h000F, 1, 1);

    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].rv;
      out_ready = vecs[i].ordy;
      req_data  = vecs[i].data;
      @(negedge clk);
      check($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(vecs[i].rr));
      check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].v));
      check($sformatf("row%0d out_data", i),  64'(out_data),  64'(vecs[i].d));
      check($sformatf("row%0d out_id", i),    64'(out_id),    64'(vecs[i].id));
      check($sformatf("row%0d out_count", i), 64'(out_count), 64'(vecs[i].c));
      @(posedge clk);
      #1;
    end

    // Randomized phase against the reference model and scoreboard.
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = '0; m_cnt = '0; last_grant = '0; sb_q.delete();

    for (int c = 0; c < 600; c++) begin
      // Requesters hold valid and data until granted.
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant[i]) begin
          req_valid[i]       = ($urandom_range(0, 2) != 0);
          req_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);

      @(negedge clk);
      exp_valid = (sb_q.size() != 0);
      can       = !exp_valid || out_ready;
      g         = model_grant(req_valid, m_ptr, found);
      exp_rr    = (can && !rst && found) ? (N'(1) << g) : '0;
      check("rnd req_ready", 64'(req_ready), 64'(exp_rr));
      check("rnd out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("rnd out_data", 64'(out_data), 64'(sb_q[0].data));
        check("rnd out_id",   64'(out_id),   64'(sb_q[0].id));
      end
      check("rnd out_count", 64'(out_count), 64'(m_cnt));
      last_grant = exp_rr;

      @(posedge clk);
      #1;
      if (rst) begin
        sb_q.delete();
        m_ptr = '0;
        m_cnt = '0;
      end else begin
        if (exp_valid && out_ready) begin
          void'(sb_q.pop_front());
          m_cnt = m_cnt + CNT_W'(1);
        end
        if (exp_rr != '0) begin
          r.data = rev(req_data[int'(g)*W +: W]);
          r.id   = g;
          sb_q.push_back(r);
          m_ptr = (g == ID_W'(N - 1)) ? '0 : g + ID_W'(1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
